// File: rtl/home_service_scheduler_pkg.sv
// Shared constants and types for the home service scheduler: channel
// indices, status display codes, FSM state encoding and small decode helpers.
package home_ctrl_pkg;

    localparam int NUM_CH = 5;

    // Channel indices, same bit order as the request vector
    localparam logic [2:0] CH_FRONT  = 3'd4;
    localparam logic [2:0] CH_REAR   = 3'd3;
    localparam logic [2:0] CH_FIRE   = 3'd2;
    localparam logic [2:0] CH_WINDOW = 3'd1;
    localparam logic [2:0] CH_TEMP   = 3'd0;

    // Status display codes
    localparam logic [2:0] DISP_IDLE    = 3'd0;
    localparam logic [2:0] DISP_FRONT   = 3'd1;
    localparam logic [2:0] DISP_REAR    = 3'd2;
    localparam logic [2:0] DISP_FIRE    = 3'd3;
    localparam logic [2:0] DISP_WINDOW  = 3'd4;
    localparam logic [2:0] DISP_TEMP    = 3'd5;
    localparam logic [2:0] DISP_TIMEOUT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVE   = 2'd1,
        S_RELEASE = 2'd2
    } state_e;

    // One-hot grant vector for a channel index
    function automatic logic [4:0] onehot5(input logic [2:0] idx);
        return 5'b00001 << idx;
    endfunction

    // Display code for a one-hot grant; zero or malformed grants show idle
    function automatic logic [2:0] disp_code(input logic [4:0] grant);
        logic [2:0] code;
        case (grant)
            5'b10000: code = DISP_FRONT;
            5'b01000: code = DISP_REAR;
            5'b00100: code = DISP_FIRE;
            5'b00010: code = DISP_WINDOW;
            5'b00001: code = DISP_TEMP;
            default:  code = DISP_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/home_service_scheduler_if.sv
// Request/grant bundle between the sensor/actuator side (master) and the
// scheduler (slave).
interface home_service_scheduler_if;
    logic [4:0] req;
    logic       done;
    logic [4:0] grant;
    logic       busy;
    logic [4:0] pending;
    logic       timeout_err;
    logic [2:0] display;

    modport master (
        output req, done,
        input  grant, busy, pending, timeout_err, display
    );

    modport slave (
        input  req, done,
        output grant, busy, pending, timeout_err, display
    );
endinterface

// File: rtl/home_service_scheduler_picker.sv
// Combinational round-robin picker: searches downward from last-1, wrapping
// 0 -> 4, ending at last; a pending fire alarm can override the rotation.
module home_rr_picker
    import home_ctrl_pkg::*;
(
    input  logic [4:0] pending_i,
    input  logic [2:0] last_i,
    input  logic       prio_fire_i,
    output logic [2:0] pick_o,
    output logic       valid_o
);

    logic [7:0] pend_ext_s;
    logic [3:0] idx_s;
    logic [2:0] rr_pick_s;

    assign pend_ext_s = {3'b000, pending_i};

    // Walk the search order backwards so the earliest position overwrites last
    always_comb begin
        rr_pick_s = CH_TEMP;
        idx_s     = 4'd0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx_s = 4'(last_i) + 4'd5 - 4'(k);
            idx_s = (idx_s >= 4'd5) ? (idx_s - 4'd5) : idx_s;
            rr_pick_s = pend_ext_s[idx_s[2:0]] ? idx_s[2:0] : rr_pick_s;
        end
    end

    // Fire-alarm priority override and valid flag
    always_comb begin
        valid_o = |pending_i;
        if (prio_fire_i && pending_i[CH_FIRE]) begin
            pick_o = CH_FIRE;
        end else begin
            pick_o = rr_pick_s;
        end
    end

endmodule

// File: rtl/home_service_scheduler.sv
// Time-sharing scheduler for the shared actuator slot: latches sensor
// requests, grants one channel at a time with a minimum dwell and a
// completion timeout, and drives the status display.
module home_service_scheduler
    import home_ctrl_pkg::*;
#(
    parameter int DWELL     = 4,
    parameter int TIMEOUT   = 16,
    parameter bit PRIO_FIRE = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    home_service_scheduler_if.slave   bus
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] ST_IDLE    = 2'(S_IDLE);
    localparam logic [1:0] ST_SERVE   = 2'(S_SERVE);
    localparam logic [1:0] ST_RELEASE = 2'(S_RELEASE);

    logic [1:0]    state_q, state_d;
    logic [4:0]    grant_q, grant_d;
    logic [4:0]    pending_q, pending_d;
    logic [2:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tout_q, tout_d;

    logic [4:0]    clr_s;
    logic [2:0]    pick_s;
    logic          pick_valid_s;
    logic          done_ok_s;
    logic          tmo_s;

    home_rr_picker u_picker (
        .pending_i   (pending_q),
        .last_i      (last_q),
        .prio_fire_i (PRIO_FIRE),
        .pick_o      (pick_s),
        .valid_o     (pick_valid_s)
    );

    // done only counts once the minimum dwell has elapsed
    assign done_ok_s = bus.done && (cnt_q >= CW'(DWELL - 1));
    assign tmo_s     = (cnt_q == CW'(TIMEOUT - 1));

    // Next-state logic for the FSM, grant, counter and pending latch
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
        clr_s   = 5'b00000;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    grant_d = onehot5(pick_s);
                    cnt_d   = '0;
                    last_d  = pick_s;
                    state_d = ST_SERVE;
                end else begin
                    grant_d = 5'b00000;
                end
            end
            ST_SERVE: begin
                cnt_d = cnt_q + CW'(1);
                if (done_ok_s) begin
                    clr_s   = grant_q;
                    grant_d = 5'b00000;
                    state_d = ST_RELEASE;
                end else if (tmo_s) begin
                    clr_s   = grant_q;
                    grant_d = 5'b00000;
                    tout_d  = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_SERVE;
                end
            end
            ST_RELEASE: begin
                grant_d = 5'b00000;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = 5'b00000;
                state_d = ST_IDLE;
            end
        endcase
        pending_d = (pending_q & ~clr_s) | bus.req;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= 5'b00000;
            pending_q <= 5'b00000;
            last_q    <= 3'd0;
            cnt_q     <= '0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            tout_q    <= tout_d;
        end
    end

    // Outputs come only from registered state
    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q == ST_SERVE);
    assign bus.pending     = pending_q;
    assign bus.timeout_err = tout_q;
    assign bus.display     = tout_q ? DISP_TIMEOUT : disp_code(grant_q);

endmodule

// File: tb/tb_home_service_scheduler.sv
// Directed testbench for home_service_scheduler: two instances (fire
// priority on and off) share one stimulus stream and are checked against
// hand-computed grant orders, hold times and status codes.
module tb_home_service_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req_r;
    logic       done_r;

    int total_cnt = 0;
    int bad_cnt   = 0;

    home_service_scheduler_if bus_p1 ();
    home_service_scheduler_if bus_p0 ();

    assign bus_p1.req  = req_r;
    assign bus_p1.done = done_r;
    assign bus_p0.req  = req_r;
    assign bus_p0.done = done_r;

    home_service_scheduler #(.DWELL(4), .TIMEOUT(16), .PRIO_FIRE(1'b1)) dut_p1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_p1)
    );

    home_service_scheduler #(.DWELL(4), .TIMEOUT(16), .PRIO_FIRE(1'b0)) dut_p0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_p0)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        req_r  = 5'b00000;
        done_r = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait for the next grant on the priority instance, check both
    // instances, then measure how many cycles the grant stays up.
    task automatic serve(input string tag,
                         input logic [4:0] g1, input logic [2:0] d1,
                         input logic [4:0] g0, input logic [2:0] d0,
                         input int len_exp, output int gap);
        int len;
        gap = 0;
        while (bus_p1.grant == 5'b00000 && gap < 40) begin
            tick();
            gap++;
        end
        check_eq({tag, "_grant_p1"}, 32'(bus_p1.grant), 32'(g1));
        check_eq({tag, "_disp_p1"},  32'(bus_p1.display), 32'(d1));
        check_eq({tag, "_grant_p0"}, 32'(bus_p0.grant), 32'(g0));
        check_eq({tag, "_disp_p0"},  32'(bus_p0.display), 32'(d0));
        check_eq({tag, "_busy"},     32'(bus_p1.busy), 32'd1);
        len = 0;
        while (bus_p1.grant == g1 && g1 != 5'b00000 && len < 40) begin
            tick();
            len++;
        end
        check_eq({tag, "_len"}, 32'(len), 32'(len_exp));
    endtask

    initial begin
        int gap;
        int len;

        // Asynchronous reset with all requests high, before any clock edge
        rst    = 1'b0;
        req_r  = 5'b11111;
        done_r = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_eq("rst_grant",   32'(bus_p1.grant), 32'd0);
        check_eq("rst_pending", 32'(bus_p1.pending), 32'd0);
        check_eq("rst_display", 32'(bus_p1.display), 32'd0);
        check_eq("rst_busy",    32'(bus_p1.busy), 32'd0);
        check_eq("rst_tout",    32'(bus_p1.timeout_err), 32'd0);
        reset_dut();

        // Single one-cycle window request, done tied high
        req_r  = 5'b00010;
        done_r = 1'b1;
        tick();
        req_r = 5'b00000;
        check_eq("pulse_grant_e1",   32'(bus_p1.grant), 32'd0);
        check_eq("pulse_pending_e1", 32'(bus_p1.pending), 32'h02);
        tick();
        serve("pulse", 5'b00010, 3'd4, 5'b00010, 3'd4, 4, gap);
        check_eq("pulse_latency", 32'(gap), 32'd0);
        check_eq("pulse_rel_pending", 32'(bus_p1.pending), 32'd0);
        check_eq("pulse_rel_display", 32'(bus_p1.display), 32'd0);
        check_eq("pulse_rel_tout",    32'(bus_p1.timeout_err), 32'd0);
        check_eq("pulse_rel_busy",    32'(bus_p1.busy), 32'd0);
        tick();
        check_eq("pulse_idle_grant", 32'(bus_p1.grant), 32'd0);

        // Round robin with held requests, no fire request involved
        reset_dut();
        req_r  = 5'b11011;
        done_r = 1'b1;
        serve("rr0", 5'b10000, 3'd1, 5'b10000, 3'd1, 4, gap);
        check_eq("rr0_gap", 32'(gap), 32'd2);
        serve("rr1", 5'b01000, 3'd2, 5'b01000, 3'd2, 4, gap);
        check_eq("rr1_gap", 32'(gap), 32'd2);
        serve("rr2", 5'b00010, 3'd4, 5'b00010, 3'd4, 4, gap);
        check_eq("rr2_gap", 32'(gap), 32'd2);
        serve("rr3", 5'b00001, 3'd5, 5'b00001, 3'd5, 4, gap);
        check_eq("rr3_gap", 32'(gap), 32'd2);
        serve("rr4", 5'b10000, 3'd1, 5'b10000, 3'd1, 4, gap);
        check_eq("rr4_gap", 32'(gap), 32'd2);
        req_r = 5'b00000;

        // Fire priority: p1 serves fire first, p0 follows plain rotation
        reset_dut();
        req_r  = 5'b10101;
        done_r = 1'b1;
        tick();
        req_r = 5'b00000;
        serve("fire0", 5'b00100, 3'd3, 5'b10000, 3'd1, 4, gap);
        serve("fire1", 5'b00001, 3'd5, 5'b00100, 3'd3, 4, gap);
        serve("fire2", 5'b10000, 3'd1, 5'b00001, 3'd5, 4, gap);
        check_eq("fire_pending_p1", 32'(bus_p1.pending), 32'd0);
        check_eq("fire_pending_p0", 32'(bus_p0.pending), 32'd0);

        // Early done ignored, then service ends by timeout
        reset_dut();
        req_r  = 5'b01000;
        done_r = 1'b0;
        tick();
        req_r = 5'b00000;
        tick();
        check_eq("to_grant", 32'(bus_p1.grant), 32'h08);
        tick();
        done_r = 1'b1;
        tick();
        done_r = 1'b0;
        check_eq("to_early_done_ignored", 32'(bus_p1.grant), 32'h08);
        len = 3;
        while (bus_p1.grant == 5'b01000 && len < 40) begin
            tick();
            len++;
        end
        check_eq("to_len",        32'(len - 1), 32'd16);
        check_eq("to_err_p1",     32'(bus_p1.timeout_err), 32'd1);
        check_eq("to_err_p0",     32'(bus_p0.timeout_err), 32'd1);
        check_eq("to_display",    32'(bus_p1.display), 32'd7);
        check_eq("to_pending",    32'(bus_p1.pending), 32'd0);
        check_eq("to_busy",       32'(bus_p1.busy), 32'd0);
        tick();
        check_eq("to_err_clear",  32'(bus_p1.timeout_err), 32'd0);
        check_eq("to_disp_clear", 32'(bus_p1.display), 32'd0);

        // Reset in the middle of a service drops the grant at once
        req_r  = 5'b01000;
        done_r = 1'b0;
        tick();
        req_r = 5'b00000;
        tick();
        check_eq("mr_grant_before", 32'(bus_p1.grant), 32'h08);
        #2 rst = 1'b1;
        #1;
        check_eq("mr_grant_p1",  32'(bus_p1.grant), 32'd0);
        check_eq("mr_grant_p0",  32'(bus_p0.grant), 32'd0);
        check_eq("mr_busy",      32'(bus_p1.busy), 32'd0);
        check_eq("mr_pending",   32'(bus_p1.pending), 32'd0);
        tick();
        tick();
        rst    = 1'b0;
        req_r  = 5'b11000;
        done_r = 1'b1;
        serve("mr0", 5'b10000, 3'd1, 5'b10000, 3'd1, 4, gap);
        serve("mr1", 5'b01000, 3'd2, 5'b01000, 3'd2, 4, gap);
        check_eq("mr1_gap", 32'(gap), 32'd2);
        req_r = 5'b00000;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/home_service_scheduler.md
# home_service_scheduler

Time-sharing scheduler for the home automation actuator path. It latches requests from the five sensor channels (front door, rear door, fire alarm, window, temperature) and grants the single shared actuator/service slot to one channel at a time. Arbitration is circular (round-robin) with optional fire-alarm priority. Each grant has a guaranteed minimum hold time and a completion handshake with a timeout. The block sits between the sensor inputs and the actuator drivers, and also drives the 3-bit status display.

## Interface
- DWELL, 4: minimum cycles a grant stays asserted; legal range 1..TIMEOUT.
- TIMEOUT, 16: maximum cycles a grant stays asserted without an accepted `done`.
- PRIO_FIRE, 1: when 1, a pending fire-alarm request wins arbitration regardless of round-robin position.
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- req  in  5  request levels, sampled each edge: bit4 front door, bit3 rear door, bit2 fire alarm, bit1 window, bit0 temperature.
- done  in  1  the granted device reports its service is complete.
- grant  out  5  one-hot (or zero) service grant; same bit order as `req`.
- busy  out  1  high while in SERVE.
- pending  out  5  latched outstanding requests.
- timeout_err  out  1  one-cycle pulse when a service ends by timeout.
- display  out  3  status code: 0 idle/release, 1 front door, 2 rear door, 3 fire alarm, 4 window, 5 temperature, 7 timeout release.

## Operation
- Pending latch update, every edge: pending <= (pending & ~clr) | req.
  - `clr` is the one-hot of the granted channel in the cycle its service ends.
  - A request held high through the end of its service re-queues.
- `last` (3 bits) records the index of the most recently granted channel; reset value 0; updated when entering SERVE.
- Round-robin search order starts at last-1 and counts down, wrapping from 0 to 4, and ends at `last`.
  - With last=0 the order is 4,3,2,1,0.
  - With last=2 the order is 1,0,4,3,2.
- If PRIO_FIRE=1 and pending[2]=1, the pick is channel 2.
  - A continuously held fire request therefore monopolizes the slot; this is intended safety behaviour.
- FSM states: IDLE, SERVE, RELEASE.
- IDLE:
  - If pending is nonzero: register grant = the one-hot of the pick, cnt <= 0, set `last`, go to SERVE.
  - Otherwise stay in IDLE.
- SERVE:
  - cnt increments each cycle.
  - `done` is accepted only when cnt >= DWELL-1; an earlier `done` is ignored.
  - On accepted `done`: clear that pending bit, go to RELEASE.
  - Else, if cnt == TIMEOUT-1: clear that pending bit, set the timeout flag, go to RELEASE.
  - If both conditions hold on the same edge, `done` wins and there is no error.
- RELEASE: grant = 0 for one cycle, then go to IDLE. `timeout_err` is high in this cycle only if the service ended by timeout.
- `done` is ignored in IDLE and RELEASE.
- cnt width: clog2(TIMEOUT)+1 bits; it never wraps.

## Timing
- Reset values:
  - state IDLE, grant 0, pending 0, last 0, cnt 0.
  - busy 0, timeout_err 0, display 0.
- Reset acts asynchronously: asserting Rst mid-SERVE drops grant without waiting for a clock edge.
- Request latency: req[i] sampled at edge E while in IDLE with nothing pending → grant[i] high after edge E+1.
- Hold time: with `done` held high, grant stays high exactly DWELL cycles. With `done` low, grant stays high exactly TIMEOUT cycles.
- Gap between consecutive grants: 2 cycles (RELEASE, then IDLE).
- All outputs are registered or decoded from registered state only; there is no combinational path from req or `done` to any output.
- display is decoded from grant; it shows 7 in a timeout RELEASE cycle and 0 in every other RELEASE or IDLE cycle.

## Structure
- Shared package `home_ctrl_pkg` holds:
  - the channel index constants (FRONT=4, REAR=3, FIRE=2, WINDOW=1, TEMP=0);
  - the display code constants (0–5, and 7);
  - the FSM state enum.
- Sub-module `home_rr_picker` is purely combinational: inputs pending[4:0], last[2:0], PRIO_FIRE; outputs the picked index and a valid flag.
- The FSM, counter and pending latch live in the top module.

## Test plan
- Reset: assert Rst with req=5'b11111 → grant=0, pending=0, display=0, busy=0 immediately, with no clock edge.
- Single pulse, done tied high: one-cycle req=5'b00010 → grant=5'b00010 for exactly 4 cycles starting after the second edge; display=4; then pending=0 and the FSM returns to IDLE.
- Round-robin: req=5'b11011 held, done=1, PRIO_FIRE=0 → grant sequence bit4, bit3, bit1, bit0, bit4…; each grant lasts 4 cycles with a 2-cycle gap.
- Fire priority: one-cycle req=5'b10101, done=1, PRIO_FIRE=1 → grant order bit2, bit0, bit4; display 3, 5, 1.
- Timeout and early done: req[3] pulse, `done` pulsed at cnt=1 and then held low → the early `done` is ignored; grant lasts 16 cycles; timeout_err pulses 1 cycle with display=7; pending[3]=0.
- Reset mid-service: assert Rst during grant=5'b01000 → grant drops asynchronously. After release, with req=5'b11000 held and done=1 → first grant is bit4 (last back to 0), then bit3.
